// File: rtl/fm_tx_pkg.sv
// fm_tx_pkg: items shared by the FM transmit blocks.
//   DW_DEF / PW_DEF : default sample and phase/tuning-word widths
//   fm_state_e      : modulator FSM encoding (IDLE=0, WARMUP=1, RUN=2)
//   WARMUP_LEN      : clocks spent in WARMUP while the sample/frequency pipeline fills
package fm_tx_pkg;

  localparam int DW_DEF     = 8;
  localparam int PW_DEF     = 24;
  localparam int WARMUP_LEN = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } fm_state_e;

endpackage

// File: rtl/fm_nco_modulator_phase_acc.sv
// fm_phase_acc: phase accumulator plus registered MSB output.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : zero the phase and the output bit
//   step        : phase <= phase + freq_word (mod 2^PW); msb_out follows the new MSB
//   mute        : force msb_out low without touching the phase
//   freq_word   : per-clock phase increment
//   phase       : accumulator value
//   msb_out     : registered MSB of the post-update phase
// Priority: clear > step > mute.
module fm_phase_acc #(
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic          mute,
  input  logic [PW-1:0] freq_word,
  output logic [PW-1:0] phase,
  output logic          msb_out
);

  logic [PW-1:0] phase_sum;

  // Natural PW-bit truncation gives the modulo-2^PW wrap.
  assign phase_sum = phase + freq_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      msb_out <= 1'b0;
    end else if (clear) begin
      phase   <= '0;
      msb_out <= 1'b0;
    end else if (step) begin
      phase   <= phase_sum;
      msb_out <= phase_sum[PW-1];
    end else if (mute) begin
      msb_out <= 1'b0;
    end
  end

endmodule

// File: rtl/fm_nco_modulator.sv
// fm_nco_modulator: FM square-wave carrier generator in the fast (dst) clock domain.
// Frequency word = carrier_word + (sign-extended sample << DEV_SHIFT), mod 2^PW;
// the accumulator MSB is the modulated 1-bit carrier.
//
// Ports:
//   clk          : fast clock (same as the CDC destination clock)
//   rst          : asynchronous active-high reset
//   enable       : run request
//   carrier_word : unsigned carrier tuning word (quasi-static)
//   sample       : signed audio sample from the CDC bus
//   fm_out       : modulated carrier (registered phase MSB)
//   phase        : accumulator value
//   sample_upd   : one-clock pulse when a new sample value enters the pipeline (RUN only)
//   running      : high in RUN
//   state_dbg    : current FSM state (fm_state_e encoding)
//
// Pipeline: stage 1 registers sample/carrier, stage 2 forms freq_word, stage 3
// steps the phase, so an input change is first used in the third clock after capture.
//
// Handshake: none. enable is a level; sample/carrier are sampled every clock.
//
// Build option: define FM_NCO_SLEW_EN to slew-limit freq_word toward its target
// by at most SLEW_STEP per clock (loaded directly on WARMUP entry).
module fm_nco_modulator
  import fm_tx_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int PW        = PW_DEF,
  parameter int DEV_SHIFT = 4,
  parameter int SLEW_STEP = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] carrier_word,
  input  logic [DW-1:0] sample,
  output logic          fm_out,
  output logic [PW-1:0] phase,
  output logic          sample_upd,
  output logic          running,
  output logic [1:0]    state_dbg
);

  localparam int CW = (WARMUP_LEN > 1) ? $clog2(WARMUP_LEN) : 1;

  fm_state_e     state, state_nxt;
  logic [CW-1:0] warm_cnt, warm_cnt_nxt;
  logic          warm_entry;

  logic [DW-1:0] sample_q;
  logic [PW-1:0] carrier_q;
  logic [PW-1:0] dev_term;
  logic [PW-1:0] target;
  logic [PW-1:0] freq_word;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    if (!enable) begin
      // Dropping enable returns to IDLE from any state.
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt    = ST_WARMUP;
          warm_cnt_nxt = CW'(WARMUP_LEN - 1);
        end
        ST_WARMUP: begin
          if (warm_cnt == '0) state_nxt = ST_RUN;
          else                warm_cnt_nxt = warm_cnt - CW'(1);
        end
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign warm_entry = (state == ST_IDLE) && enable;
  assign running    = (state == ST_RUN);
  assign state_dbg  = state;

  // ---------------- Stage 1: capture ----------------
  // sample_upd is qualified by the next state, so an enable drop on the same
  // edge as a sample change suppresses the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= '0;
      carrier_q  <= '0;
      sample_upd <= 1'b0;
    end else begin
      sample_q   <= sample;
      carrier_q  <= carrier_word;
      sample_upd <= (state_nxt == ST_RUN) && (sample != sample_q);
    end
  end

  // ---------------- Stage 2: frequency word ----------------
  assign dev_term = {{(PW-DW){sample_q[DW-1]}}, sample_q} << DEV_SHIFT;
  assign target   = carrier_q + dev_term;

`ifdef FM_NCO_SLEW_EN
  localparam logic signed [PW:0] STEP_S = (PW+1)'(SLEW_STEP);
  logic signed [PW:0] diff;

  // One extra bit keeps the distance signed and free of wrap overshoot.
  assign diff = $signed({1'b0, target}) - $signed({1'b0, freq_word});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                freq_word <= '0;
    else if (warm_entry)    freq_word <= target;
    else if (diff > STEP_S) freq_word <= freq_word + PW'(SLEW_STEP);
    else if (diff < -STEP_S) freq_word <= freq_word - PW'(SLEW_STEP);
    else                    freq_word <= target;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) freq_word <= '0;
    else     freq_word <= target;
  end
`endif

  // ---------------- Stage 3: accumulator ----------------
  fm_phase_acc #(
    .PW (PW)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear     (warm_entry),
    .step      (running && enable),
    .mute      (!enable),
    .freq_word (freq_word),
    .phase     (phase),
    .msb_out   (fm_out)
  );

endmodule

// File: tb/tb_fm_nco_modulator.sv
module tb_fm_nco_modulator;
  import fm_tx_pkg::*;

  localparam int DW        = 8;
  localparam int PW        = 24;
  localparam int DEV_SHIFT = 4;
  localparam int SLEW_STEP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] carrier_word;
  logic [DW-1:0] sample;
  logic          fm_out;
  logic [PW-1:0] phase;
  logic          sample_upd;
  logic          running;
  logic [1:0]    state_dbg;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fm_nco_modulator #(
    .DW        (DW),
    .PW        (PW),
    .DEV_SHIFT (DEV_SHIFT),
    .SLEW_STEP (SLEW_STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .carrier_word (carrier_word),
    .sample       (sample),
    .fm_out       (fm_out),
    .phase        (phase),
    .sample_upd   (sample_upd),
    .running      (running),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // h_s/h_c hold the inputs seen at the two previous edges (oldest first).
  logic [DW-1:0] h_s[$];
  logic [PW-1:0] h_c[$];
  logic [PW-1:0] exp_q[$];
  int            en_run;   // consecutive edges with enable high, capped at 4
  logic [PW-1:0] m_phase;
  logic [PW-1:0] m_fw;     // only used when slewing
  logic          m_fm;
  logic          m_upd;

  function automatic logic [PW-1:0] fw_of(input logic [DW-1:0] s, input logic [PW-1:0] c);
    int sv;
    sv = int'($signed(s));
    return c + PW'(sv * (1 << DEV_SHIFT));
  endfunction

  task automatic model_reset();
    h_s = {8'h00, 8'h00};
    h_c = {24'h0, 24'h0};
    exp_q.delete();
    en_run  = 0;
    m_phase = '0;
    m_fw    = '0;
    m_fm    = 1'b0;
    m_upd   = 1'b0;
  endtask

  task automatic model_edge(input bit en, input logic [DW-1:0] s, input logic [PW-1:0] c);
    logic [PW-1:0] step_fw;
`ifdef FM_NCO_SLEW_EN
    logic [PW-1:0] tgt;
    int d;
    step_fw = m_fw;
    tgt     = fw_of(h_s[1], h_c[1]);
`else
    step_fw = fw_of(h_s[0], h_c[0]);
`endif
    en_run = en ? ((en_run >= 4) ? 4 : en_run + 1) : 0;
`ifdef FM_NCO_SLEW_EN
    if (en_run == 1) m_fw = tgt;
    else begin
      d = int'(tgt) - int'(m_fw);
      if (d > SLEW_STEP)       m_fw = m_fw + PW'(SLEW_STEP);
      else if (d < -SLEW_STEP) m_fw = m_fw - PW'(SLEW_STEP);
      else                     m_fw = tgt;
    end
`endif
    if (!en) m_fm = 1'b0;
    else if (en_run == 1) begin
      m_phase = '0;
      m_fm    = 1'b0;
    end else if (en_run == 4) begin
      m_phase = m_phase + step_fw;
      m_fm    = m_phase[PW-1];
    end
    m_upd = (en_run >= 3) && (s != h_s[1]);
    h_s.push_back(s);  void'(h_s.pop_front());
    h_c.push_back(c);  void'(h_c.pop_front());
    exp_q.push_back(m_phase);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst          = 1'b1;
    enable       = 1'b0;
    sample       = '0;
    carrier_word = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input bit en, input logic [DW-1:0] s, input logic [PW-1:0] c);
    logic [1:0] st_exp;
    enable       = en;
    sample       = s;
    carrier_word = c;
    @(posedge clk);
    model_edge(en, s, c);
    #1;
    st_exp = (en_run == 0) ? ST_IDLE : (en_run < 3) ? ST_WARMUP : ST_RUN;
    check("phase", phase, exp_q.pop_front());
    check("fm_out", fm_out, m_fm);
    check("running", running, en_run >= 3);
    check("sample_upd", sample_upd, m_upd);
    check("state", state_dbg, st_exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rs;
    logic [PW-1:0] rc;
    bit            ren;

    rst = 1'b1; enable = 1'b0; sample = '0; carrier_word = '0;
    do_reset();
    check("rst_phase", phase, 0);
    check("rst_fm", fm_out, 0);
    check("rst_running", running, 0);
    check("rst_upd", sample_upd, 0);

    // Step to phase 0x123456 then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00, 24'h123456);
`ifndef FM_NCO_SLEW_EN
    check("dir_phase_123456", phase, 24'h123456);
`endif
    #3 rst = 1'b1;
    #1;
    check("async_phase", phase, 0);
    check("async_fm", fm_out, 0);
    check("async_running", running, 0);
    check("async_state", state_dbg, ST_IDLE);
    do_reset();

    // Carrier only, then deviation, negative sample and zero-frequency wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h00, 24'h400000);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 8'h10, 24'h400000);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 8'hF0, 24'h400000);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 8'h01, 24'hFFFFF0);
    // Enable drop together with a sample change.
    cycle(1'b0, 8'h22, 24'hFFFFF0);
    cycle(1'b0, 8'h22, 24'hFFFFF0);

    // Enable drop with phase at 0x800000, then re-enable.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00, 24'h400000);
`ifndef FM_NCO_SLEW_EN
    check("drop_pre_phase", phase, 24'h800000);
`endif
    cycle(1'b0, 8'h00, 24'h400000);
`ifndef FM_NCO_SLEW_EN
    check("drop_hold_phase", phase, 24'h800000);
`endif
    check("drop_fm", fm_out, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 24'h400000);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00, 24'h400000);

    // Randomized run with occasional enable drops and tuning changes.
    rs  = '0;
    rc  = 24'h200000;
    for (int i = 0; i < 500; i++) begin
      ren = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 3) == 0)  rs = DW'($urandom);
      if ($urandom_range(0, 39) == 0) rc = PW'($urandom);
      cycle(ren, rs, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_nco_modulator.md
Name: fm_nco_modulator

Overview:
Fast-clock-domain consumer of the slow-to-fast CDC bus output: takes the held audio sample and a static carrier tuning word, and produces an FM-modulated 1-bit square-wave carrier via a phase accumulator.
Frequency word = carrier_word + (sign-extended sample << DEV_SHIFT).
Sits directly downstream of the CDC stage, upstream of the output pad/driver.

Parameters:
DW, 8, sample width (two's complement, matches the CDC bus width)
PW, 24, phase accumulator / tuning word width
DEV_SHIFT, 4, left shift applied to the sample to set the frequency deviation
SLEW_STEP, 16, max per-cycle change of the frequency word (used only with the optional feature)

Ports:
clk  in  1  fast (dst) clock; same clock as the CDC destination
rst  in  1  asynchronous, active-high reset
enable  in  1  run request; synchronous to clk
carrier_word  in  PW  unsigned carrier tuning word; quasi-static
sample  in  DW  signed sample from the CDC bus output; changes at most once per slow sample period
fm_out  out  1  modulated carrier (phase MSB, registered)
phase  out  PW  current phase accumulator value
sample_upd  out  1  one-clk pulse when a new sample value is taken into the pipeline
running  out  1  high in RUN state

Behaviour:
- Reset (async, rst=1): all registers 0; fm_out=0, phase=0, sample_upd=0, running=0; FSM=IDLE.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE -> WARMUP when enable=1. On entry to WARMUP: phase cleared to 0, 2-cycle counter loaded.
  - WARMUP -> RUN after 2 clks (pipeline filled).
  - Any state -> IDLE on enable=0 at the next edge. phase holds its value; fm_out forced 0; running=0.
  - enable re-asserted mid-WARMUP: no effect (already counting).
- Stage 1: sample_q <= sample every clk in all states. sample_upd=1 for one clk when sample_q != previous sample_q, and only in RUN.
- Stage 2: freq_word <= carrier_word + (sext(sample_q,PW) << DEV_SHIFT), modulo 2^PW.
  - Wrap-around is silent, no saturation; a negative sum wraps high.
- Stage 3 (RUN only): phase <= phase + freq_word, modulo 2^PW. fm_out <= phase[PW-1] (post-update value).
- Latency: sample change sampled at edge n reaches sample_q at n+1 and freq_word at n+2. First phase step using it occurs at n+3.
- carrier_word changes take effect the same way, 2 clks after capture.
- freq_word=0 (e.g. wrap to zero): phase frozen, fm_out constant. This is legal, not an error.
- Simultaneous enable fall and sample change: IDLE wins; sample_upd suppressed.
- rst mid-RUN: immediate clear of all state. No partial output.

Optional Feature:
Macro FM_NCO_SLEW_EN.
- Defined: stage 2 computes target = carrier_word + (sext(sample_q) << DEV_SHIFT).
  - freq_word moves toward target by at most SLEW_STEP per clk. Difference is computed signed (PW+1 bits), so there is no wrap-induced overshoot.
  - freq_word is loaded directly with target on WARMUP entry.
- Not defined: freq_word = target every clk; SLEW_STEP is unused.

Decomposition:
- Shared package fm_tx_pkg:
  - PW and DW defaults
  - FSM state encoding (IDLE=2'd0, WARMUP=2'd1, RUN=2'd2)
  - warmup length constant (2)
- One natural sub-module, fm_phase_acc: accumulator + MSB output register, with enable and clear. FSM, sample pipeline and frequency-word logic stay in the top module.

Test Plan:
- Reset: assert rst mid-RUN with phase=0x123456 -> fm_out=0, phase=0, running=0 immediately, before the next clk edge.
- Carrier only: carrier_word=0x400000, sample=0, enable=1 -> running after 2 clks; phase steps 0x400000/clk; fm_out period 4 clks (2 high, 2 low).
- Deviation and latency: in RUN, sample 0 -> 0x10 (DEV_SHIFT=4) at edge n -> sample_upd pulses at n+1; phase increment becomes 0x400100 starting at edge n+3.
- Negative sample: sample=0xF0 (-16) -> freq_word=0x3FFF00. Wrap case: carrier=0xFFFFF0, sample=+1 -> freq_word=0, phase frozen.
- Enable drop: enable=0 during RUN with phase=0x800000 -> IDLE; fm_out=0, phase holds 0x800000. Re-enable -> phase restarts from 0 after WARMUP.
- FM_NCO_SLEW_EN: SLEW_STEP=16, target jumps by +0x100 -> freq_word ramps +0x10/clk over 16 clks, then holds exactly at target.
